// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Operation request / result bundle between the controller and alu_seq.
//
// Parameters
//   DATA_W  operand/result width (multiple of 4, at least 8)
//   OP_W    width of i_operation
//
// Signals
//   i_start      operation request, sampled only when the ALU is accepting
//   i_operation  opcode (0 NOP, 1 ADD, 2 ADDC, 3 SUB, 4 AND, 5 XOR, 6 OR,
//                7 MUL, 8 DIV, 9 DA, anything else NOP)
//   i_src1       operand A
//   i_src2       operand B
//   i_srcC       carry in
//   i_srcAc      aux carry in
//   o_des1       result (low product / quotient)
//   o_des2       second result (high product / remainder), 0 for other ops
//   o_desC       carry / borrow
//   o_desAc      aux carry (nibble 0)
//   o_desOv      overflow
//   o_busy       high while an iterative op is executing
//   o_done       one-cycle completion pulse
//
// Modports
//   master  controller side (drives the request, observes the result)
//   slave   ALU side
// -----------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4
);
   logic              i_start;
   logic [OP_W-1:0]   i_operation;
   logic [DATA_W-1:0] i_src1;
   logic [DATA_W-1:0] i_src2;
   logic              i_srcC;
   logic              i_srcAc;
   logic [DATA_W-1:0] o_des1;
   logic [DATA_W-1:0] o_des2;
   logic              o_desC;
   logic              o_desAc;
   logic              o_desOv;
   logic              o_busy;
   logic              o_done;

   modport master (
      output i_start, i_operation, i_src1, i_src2, i_srcC, i_srcAc,
      input  o_des1, o_des2, o_desC, o_desAc, o_desOv, o_busy, o_done
   );

   modport slave (
      input  i_start, i_operation, i_src1, i_src2, i_srcC, i_srcAc,
      output o_des1, o_des2, o_desC, o_desAc, o_desOv, o_busy, o_done
   );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU between the controller and the ACC/B/PSW datapath.
// Single-cycle ops (NOP, ADD, ADDC, SUB, AND, XOR, OR, DA) complete in the
// cycle after acceptance; MUL (shift-add) and DIV (restoring) iterate one bit
// per cycle for DATA_W cycles. All results are registered and stay stable
// until the next o_done.
//
// Parameters
//   DATA_W  operand/result width (multiple of 4, at least 8)
//   OP_W    opcode width (at least 4)
//
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset; aborts any operation in flight
//   bus      alu_seq_if.slave: start/operation/operands in, results,
//            flags, o_busy and o_done out
//
// Build option
//   ALU_DIV_EN  when defined, the iterative divider is built (divide by zero
//               completes in one cycle with quotient all ones, remainder A,
//               OV set). When undefined, DIV behaves as NOP.
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   alu_seq_if.slave  bus
);

   localparam int NIB   = DATA_W / 4;
   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_ADDC = 4'd2,
      OP_SUB  = 4'd3,
      OP_AND  = 4'd4,
      OP_XOR  = 4'd5,
      OP_OR   = 4'd6,
      OP_MUL  = 4'd7,
      OP_DIV  = 4'd8,
      OP_DA   = 4'd9
   } op_t;

   state_t            state, state_nx;
   op_t               op_in, op_q;
   logic              accept;
   logic              is_multi;
   logic              exec_last;

   // Iteration registers: opnd_q is the multiplicand or divisor; work_hi is
   // the running high product or partial remainder; work_lo is the multiplier
   // being shifted out or the dividend shifting into the quotient.
   logic [DATA_W-1:0] opnd_q;
   logic [DATA_W-1:0] work_hi, work_lo;
   logic [CNT_W-1:0]  cnt;

   // Registered results.
   logic [DATA_W-1:0] des1_q, des2_q;
   logic              c_q, ac_q, ov_q;

   // Single-cycle results and next iteration values.
   logic [DATA_W-1:0] sc_des1, sc_des2;
   logic              sc_c, sc_ac, sc_ov;
   logic [DATA_W-1:0] step_hi, step_lo;
   logic [DATA_W:0]   mul_sum;

   // Adder / subtractor slices for the full word, nibble 0 and the low
   // DATA_W-1 bits (the last one yields the carry/borrow into the MSB).
   logic              add_cin;
   logic [DATA_W:0]   add_full, sub_full;
   logic [4:0]        add_nib, sub_nib;
   logic [DATA_W-1:0] add_low, sub_low;

   // ---------------------------------------------------------------------------
   // Decimal adjust: walk the nibbles from the bottom, adding 6 to each one
   // that is out of BCD range or flagged by AC (nibble 0) / the running carry
   // (top nibble). The running carry only ever gets set.
   // ---------------------------------------------------------------------------
   function automatic logic [DATA_W:0] da_adjust(
      input logic [DATA_W-1:0] a,
      input logic              c,
      input logic              ac
   );
      logic [DATA_W-1:0] v;
      logic [DATA_W:0]   t;
      logic              cy;
      v  = a;
      cy = c;
      for (int k = 0; k < NIB; k++) begin
         if ((v[4*k +: 4] > 4'd9) || ((k == 0) && ac) || ((k == NIB - 1) && cy)) begin
            t  = {1'b0, v} + ((DATA_W+1)'(6) << (4 * k));
            v  = t[DATA_W-1:0];
            cy = cy | t[DATA_W];
         end
      end
      return {cy, v};
   endfunction

   // ---------------------------------------------------------------------------
   // Opcode decode; codes above DA (including wide-opcode values) are NOP.
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb assigns each of its outputs a default first, so
   // no path through the block can leave a value unassigned and infer a latch.
   always_comb begin
      op_in = OP_NOP;
      if (bus.i_operation < OP_W'(10)) begin
         op_in = op_t'(bus.i_operation[3:0]);
      end
   end

   assign accept    = bus.i_start && (state != ST_EXEC);
   assign exec_last = (cnt == CNT_W'(DATA_W - 1));

   // Only MUL and a DIV with a non-zero divisor need the EXEC state.
   always_comb begin
      is_multi = (op_in == OP_MUL);
`ifdef ALU_DIV_EN
      if ((op_in == OP_DIV) && (bus.i_src2 != '0)) begin
         is_multi = 1'b1;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_nx = is_multi ? ST_EXEC : ST_DONE;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (exec_last) begin
               state_nx = ST_DONE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.o_busy = (state == ST_EXEC);
      bus.o_done = (state == ST_DONE);
   end

   // ---------------------------------------------------------------------------
   // Single-cycle datapath, evaluated on the live inputs at acceptance
   // ---------------------------------------------------------------------------
   assign add_cin  = (op_in == OP_ADDC) && bus.i_srcC;
   assign add_full = {1'b0, bus.i_src1} + {1'b0, bus.i_src2} + (DATA_W+1)'(add_cin);
   assign add_nib  = {1'b0, bus.i_src1[3:0]} + {1'b0, bus.i_src2[3:0]} + 5'(add_cin);
   assign add_low  = {1'b0, bus.i_src1[DATA_W-2:0]} + {1'b0, bus.i_src2[DATA_W-2:0]}
                   + DATA_W'(add_cin);
   assign sub_full = {1'b0, bus.i_src1} - {1'b0, bus.i_src2} - (DATA_W+1)'(bus.i_srcC);
   assign sub_nib  = {1'b0, bus.i_src1[3:0]} - {1'b0, bus.i_src2[3:0]} - 5'(bus.i_srcC);
   assign sub_low  = {1'b0, bus.i_src1[DATA_W-2:0]} - {1'b0, bus.i_src2[DATA_W-2:0]}
                   - DATA_W'(bus.i_srcC);

   always_comb begin
      sc_des1 = des1_q;
      sc_des2 = '0;
      sc_c    = c_q;
      sc_ac   = ac_q;
      sc_ov   = ov_q;
      case (op_in)
         OP_ADD, OP_ADDC: begin
            sc_des1 = add_full[DATA_W-1:0];
            sc_c    = add_full[DATA_W];
            sc_ac   = add_nib[4];
            sc_ov   = add_low[DATA_W-1] ^ add_full[DATA_W];
         end
         OP_SUB: begin
            // The top bit of each wrapped difference is the borrow out.
            sc_des1 = sub_full[DATA_W-1:0];
            sc_c    = sub_full[DATA_W];
            sc_ac   = sub_nib[4];
            sc_ov   = sub_low[DATA_W-1] ^ sub_full[DATA_W];
         end
         OP_AND: sc_des1 = bus.i_src1 & bus.i_src2;
         OP_XOR: sc_des1 = bus.i_src1 ^ bus.i_src2;
         OP_OR:  sc_des1 = bus.i_src1 | bus.i_src2;
         OP_DA:  {sc_c, sc_des1} = da_adjust(bus.i_src1, bus.i_srcC, bus.i_srcAc);
`ifdef ALU_DIV_EN
         OP_DIV: begin
            // Only a zero divisor reaches this path; others go through EXEC.
            sc_des1 = '1;
            sc_des2 = bus.i_src1;
            sc_c    = 1'b0;
            sc_ov   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Iteration step for MUL (shift-add) and DIV (restoring)
   // ---------------------------------------------------------------------------
`ifdef ALU_DIV_EN
   logic [DATA_W:0] div_shift, div_diff;
   logic            div_ge;
`endif

   always_comb begin
      // MUL: conditionally add the multiplicand, then shift the pair right.
      mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : '0);
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], work_lo[DATA_W-1:1]};
`ifdef ALU_DIV_EN
      // DIV: shift the next dividend bit into the partial remainder and keep
      // the subtraction only if it does not go negative.
      div_shift = {work_hi, work_lo[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      if (op_q == OP_DIV) begin
         step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
         step_lo = {work_lo[DATA_W-2:0], div_ge};
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Registered datapath
   // ---------------------------------------------------------------------------
   // NOTE: clocked processes use only non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         op_q    <= OP_NOP;
         opnd_q  <= '0;
         work_hi <= '0;
         work_lo <= '0;
         cnt     <= '0;
         des1_q  <= '0;
         des2_q  <= '0;
         c_q     <= 1'b0;
         ac_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else if (accept) begin
         op_q    <= op_in;
         cnt     <= '0;
         work_hi <= '0;
         opnd_q  <= (op_in == OP_MUL) ? bus.i_src1 : bus.i_src2;
         work_lo <= (op_in == OP_MUL) ? bus.i_src2 : bus.i_src1;
         if (!is_multi) begin
            des1_q <= sc_des1;
            des2_q <= sc_des2;
            c_q    <= sc_c;
            ac_q   <= sc_ac;
            ov_q   <= sc_ov;
         end
      end else if (state == ST_EXEC) begin
         work_hi <= step_hi;
         work_lo <= step_lo;
         cnt     <= cnt + 1'b1;
         if (exec_last) begin
            // Both ops leave the low result in work_lo and the high result
            // (product high half / remainder) in work_hi.
            des1_q <= step_lo;
            des2_q <= step_hi;
            c_q    <= 1'b0;
            ov_q   <= (op_q == OP_MUL) && (step_hi != '0);
         end
      end
   end

   assign bus.o_des1  = des1_q;
   assign bus.o_des2  = des2_q;
   assign bus.o_desC  = c_q;
   assign bus.o_desAc = ac_q;
   assign bus.o_desOv = ov_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed testbench for alu_seq (DATA_W=8, OP_W=4). Each scenario task drives
// its own vectors and compares the packed observation
// {done, busy, des1, des2, C, AC, OV} against hand-computed values.
// Honours ALU_DIV_EN for the divider scenarios.
// -----------------------------------------------------------------------------
module tb_alu_seq;
   localparam int DATA_W = 8;
   localparam int OP_W   = 4;

   localparam logic [3:0] NOP  = 4'd0;
   localparam logic [3:0] ADD  = 4'd1;
   localparam logic [3:0] ADDC = 4'd2;
   localparam logic [3:0] SUB  = 4'd3;
   localparam logic [3:0] AND_ = 4'd4;
   localparam logic [3:0] XOR_ = 4'd5;
   localparam logic [3:0] OR_  = 4'd6;
   localparam logic [3:0] MUL  = 4'd7;
   localparam logic [3:0] DIV  = 4'd8;
   localparam logic [3:0] DA   = 4'd9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [20:0] exp;

   alu_seq_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

   alu_seq #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [20:0] obs();
      return {bus.o_done, bus.o_busy, bus.o_des1, bus.o_des2,
              bus.o_desC, bus.o_desAc, bus.o_desOv};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic ac, input logic start);
      bus.i_operation = op;
      bus.i_src1      = a;
      bus.i_src2      = b;
      bus.i_srcC      = c;
      bus.i_srcAc     = ac;
      bus.i_start     = start;
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic ac);
      drive(op, a, b, c, ac, 1'b1);
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic test_reset();
      drive(NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) tick();
      exp = '0;
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL reset_state: got %h required %h", obs(), exp);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL idle_after_reset: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_add();
      issue(ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL add_7f_01: got %h required %h", obs(), exp);
      end
      tick();
      exp = {1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL done_one_cycle: got %h required %h", obs(), exp);
      end
      issue(ADDC, 8'hFF, 8'h00, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL addc_ff_00_c: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_sub();
      issue(SUB, 8'h00, 8'h01, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL sub_00_01_c: got %h required %h", obs(), exp);
      end
      issue(SUB, 8'h80, 8'h01, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL sub_80_01: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_logic();
      // Flags are C=0 AC=1 OV=1 from the last SUB and must hold; the carry
      // inputs are driven opposite to prove they are ignored.
      issue(AND_, 8'hF0, 8'h3C, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL and_f0_3c: got %h required %h", obs(), exp);
      end
      issue(XOR_, 8'hF0, 8'h3C, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'hCC, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL xor_f0_3c: got %h required %h", obs(), exp);
      end
      issue(OR_, 8'hF0, 8'h3C, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'hFC, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL or_f0_3c: got %h required %h", obs(), exp);
      end
      issue(NOP, 8'h11, 8'h22, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL nop_holds: got %h required %h", obs(), exp);
      end
      issue(4'hF, 8'h11, 8'h22, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL undefined_op_nop: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_mul();
      int cycles;
      int busy_cnt;
      issue(MUL, 8'h50, 8'hA0, 1'b1, 1'b0);
      // First EXEC cycle: busy, previous results still presented.
      exp = {1'b0, 1'b1, 8'hFC, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL mul_exec_hold: got %h required %h", obs(), exp);
      end
      cycles   = 1;
      busy_cnt = 0;
      while (!bus.o_done && cycles < 40) begin
         if (bus.o_busy) busy_cnt++;
         if (cycles == 3) drive(ADD, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
         else bus.i_start = 1'b0;
         tick();
         cycles++;
      end
      bus.i_start = 1'b0;
      checks++;
      if (cycles !== 9) begin
         errors++;
         $display("FAIL mul_done_latency: got %0d required 9", cycles);
      end
      checks++;
      if (busy_cnt !== 8) begin
         errors++;
         $display("FAIL mul_busy_cycles: got %0d required 8", busy_cnt);
      end
      exp = {1'b1, 1'b0, 8'h00, 8'h32, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL mul_50_a0: got %h required %h", obs(), exp);
      end
      tick();
      exp = {1'b0, 1'b0, 8'h00, 8'h32, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL mul_after_done: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_div();
`ifdef ALU_DIV_EN
      int cycles;
      issue(DIV, 8'hFB, 8'h12, 1'b1, 1'b0);
      cycles = 1;
      while (!bus.o_done && cycles < 40) begin
         tick();
         cycles++;
      end
      checks++;
      if (cycles !== 9) begin
         errors++;
         $display("FAIL div_done_latency: got %0d required 9", cycles);
      end
      exp = {1'b1, 1'b0, 8'h0D, 8'h11, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL div_fb_12: got %h required %h", obs(), exp);
      end
      issue(DIV, 8'hFB, 8'h00, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'hFF, 8'hFB, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL div_by_zero: got %h required %h", obs(), exp);
      end
`else
      // Without the divider DIV is a NOP: one-cycle done, des1 held,
      // des2 cleared, flags held.
      issue(DIV, 8'hFB, 8'h12, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL div_as_nop: got %h required %h", obs(), exp);
      end
`endif
   endtask

   task automatic test_da();
      issue(ADD, 8'h56, 8'h67, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 8'hBD, 8'h00, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL add_56_67: got %h required %h", obs(), exp);
      end
      issue(DA, 8'hBD, 8'h00, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 8'h23, 8'h00, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL da_bd: got %h required %h", obs(), exp);
      end
      issue(DA, 8'h99, 8'h00, 1'b0, 1'b1);
      exp = {1'b1, 1'b0, 8'h9F, 8'h00, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL da_99_ac: got %h required %h", obs(), exp);
      end
      issue(DA, 8'h00, 8'h00, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL da_00_c: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_back_to_back();
      drive(ADD, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
      tick();
      exp = {1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL b2b_first: got %h required %h", obs(), exp);
      end
      drive(ADD, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
      tick();
      exp = {1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL b2b_second: got %h required %h", obs(), exp);
      end
      drive(ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
      tick();
      exp = {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL b2b_third: got %h required %h", obs(), exp);
      end
      bus.i_start = 1'b0;
      tick();
      exp = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL b2b_release: got %h required %h", obs(), exp);
      end
   endtask

   task automatic test_reset_mid_mul();
      int done_seen;
      issue(MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
      repeat (3) tick();
      checks++;
      if (bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_mul_busy: got %b required 1", bus.o_busy);
      end
      rst_n = 1'b0;
      tick();
      exp = '0;
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL reset_mid_mul: got %h required %h", obs(), exp);
      end
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.o_done) done_seen++;
         tick();
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL aborted_no_done: got %0d done pulses required 0", done_seen);
      end
      issue(ADD, 8'h01, 8'h01, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL add_after_abort: got %h required %h", obs(), exp);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_mul();
      test_div();
      test_da();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the core ALU, sitting between the controller and the accumulator/B/PSW datapath.
- Adds registered outputs, a start/done handshake, iterative MUL and DIV, and decimal adjust (DA).
- Keeps ADD/ADDC/SUB/AND/XOR/OR with 8051 flag semantics at any nibble-multiple width.
- The controller issues an operation with operands and waits for o_done, stalling while o_busy is high.

Parameters:
DATA_W, 8, operand/result width; must be a multiple of 4 and at least 8.
OP_W, 4, width of i_operation.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous reset, active-low
i_start  input  1  operation request; sampled only when accepting
i_operation  input  OP_W  0 NOP, 1 ADD, 2 ADDC, 3 SUB, 4 AND, 5 XOR, 6 OR, 7 MUL, 8 DIV, 9 DA, others NOP
i_src1  input  DATA_W  operand A
i_src2  input  DATA_W  operand B
i_srcC  input  1  carry in
i_srcAc  input  1  aux carry in
o_des1  output  DATA_W  result (low product / quotient)
o_des2  output  DATA_W  second result (high product / remainder); 0 for other ops
o_desC  output  1  carry / borrow
o_desAc  output  1  aux carry (nibble 0)
o_desOv  output  1  overflow
o_busy  output  1  high while in EXEC
o_done  output  1  one-cycle pulse; outputs valid and stable from this cycle until next done

Behaviour:
- Reset: clock and reset are fixed — one clock i_clk; reset i_rst_n is synchronous and active-low. While i_rst_n is low at a rising edge: state goes to IDLE, and all outputs, o_busy and o_done are 0. This holds even mid-operation; no o_done is produced for an aborted operation.
- States: IDLE, EXEC, DONE.
- Accepting: a start is accepted when i_start=1 in IDLE or DONE. Operands, op, i_srcC and i_srcAc are captured at acceptance. i_start during EXEC is ignored (no queueing).
- Single-cycle ops (NOP, ADD, ADDC, SUB, AND, XOR, OR, DA): go straight to DONE. o_done is high in the cycle after acceptance.
- Back-to-back issue: holding i_start high with single-cycle ops gives o_done every cycle.
- MUL/DIV: go to EXEC for DATA_W cycles (o_busy=1), then DONE. o_done comes DATA_W+1 cycles after acceptance.
- DONE: lasts one cycle, then IDLE unless a new start is accepted.
- ADD/ADDC:
  - sum = A + B (+ C for ADDC).
  - C = carry out of the MSB.
  - AC = carry out of bit 3.
  - OV = carry into MSB xor carry out of MSB.
- SUB: A - B - C.
  - C = borrow out of the MSB.
  - AC = borrow out of bit 3.
  - OV = borrow into MSB xor borrow out of MSB.
- AND/XOR/OR, NOP: o_des1 = result (NOP leaves o_des1 unchanged). o_desC, o_desAc and o_desOv hold their previous values.
- MUL: unsigned shift-add, one bit per EXEC cycle.
  - {o_des2, o_des1} = A*B.
  - C = 0; OV = (o_des2 != 0); AC holds.
- DIV: unsigned restoring division, one quotient bit per EXEC cycle.
  - o_des1 = quotient, o_des2 = remainder.
  - C = 0; OV = 0; AC holds.
- DA: start with v = A.
  - For each nibble k, from nibble 0 upward: add 6<<(4k) to v if nibble k of the current v > 9, or (k=0 and AC), or (k=top and C).
  - Any carry out of the MSB sets C. C is never cleared by DA.
  - AC and OV hold.
- Unselected outputs for each op hold unless stated; o_des2 = 0 for all non-MUL/DIV ops.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: DIV behaves as above. Divisor 0 is detected at acceptance and skips EXEC, so o_done comes the next cycle, with o_des1 = all ones, o_des2 = A, OV = 1, C = 0.
- Undefined: no divider logic is built. DIV (op 8) is treated as NOP: one-cycle done, o_des1 unchanged, o_des2 = 0, flags hold.

Test Plan:
1. ADD A=0x7F B=0x01 -> next cycle o_done=1, o_des1=0x80, C=0, AC=1, OV=1.
2. SUB A=0x00 B=0x01 C=1 -> o_des1=0xFE, C=1, AC=1, OV=0.
3. MUL A=0x50 B=0xA0 -> o_busy for 8 cycles, o_done 9 cycles after start, o_des2=0x32, o_des1=0x00, C=0, OV=1. Start pulsed mid-EXEC is ignored.
4. DIV A=0xFB B=0x12 -> o_des1=0x0D, o_des2=0x11, OV=0. With ALU_DIV_EN, B=0x00 -> one-cycle done, o_des1=0xFF, o_des2=0xFB, OV=1.
5. ADD 0x56+0x67 -> 0xBD, C=0, AC=0. Then DA with those flags -> o_des1=0x23, C=1.
6. Reset mid-MUL: drive i_rst_n=0 in the 4th EXEC cycle -> next edge IDLE, all outputs 0, no o_done. Then ADD 0x01+0x01 -> 0x02 one cycle later.
